attack_arbiter: RTL

ATTACK_ARBITER -- requirements
Module: attack_arbiter

---
 rtl/attack_pkg.sv | 47 ++++
 rtl/attack_arbiter_if.sv | 27 ++
 rtl/attack_frame_timer.sv | 24 ++
 rtl/attack_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/attack_pkg.sv
// Shared types and constants for the attack launch arbiter: keycodes,
// FSM states, grant encoding and the cooldown load helper.
package attack_pkg;

  localparam int unsigned CD_W   = 4;
  localparam int unsigned TO_W   = 5;
  localparam int unsigned AMMO_W = 4;

  typedef enum logic [7:0] {
    KEY_X     = 8'd27,
    KEY_Z     = 8'd29,
    KEY_SPACE = 8'd44,
    KEY_RIGHT = 8'd79,
    KEY_LEFT  = 8'd80,
    KEY_DOWN  = 8'd81,
    KEY_UP    = 8'd82
  } key_e;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } keypair_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_LAUNCH,
    ST_ACTIVE,
    ST_COOLDOWN
  } state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_A1   = 2'b01,
    GRANT_A2   = 2'b10
  } grant_e;

  // Higher levels shorten the cooldown, never below one frame
  function automatic logic [CD_W-1:0] cooldown_load(input int unsigned base,
                                                    input logic [1:0] lvl_hi);
    int unsigned hi;
    hi = 32'(lvl_hi);
    if (base > hi + 1) return CD_W'(base - hi);
    return CD_W'(1);
  endfunction

endpackage

// File: rtl/attack_arbiter_if.sv
// Game-side bus of the attack arbiter: key input, attack object status,
// launch strobes and arbiter status.
interface attack_arbiter_if;
  import attack_pkg::*;

  logic       game_frame_clk_rising_edge;
  keypair_t   keycode;
  logic       Attack1_On;
  logic       Attack2_On;
  logic [3:0] Game_Level;
  logic       Fire1;
  logic       Fire2;
  logic [1:0] Grant;
  logic       Ready;
  logic [3:0] Ammo;

  modport master (
    output game_frame_clk_rising_edge, keycode, Attack1_On, Attack2_On, Game_Level,
    input  Fire1, Fire2, Grant, Ready, Ammo
  );

  modport slave (
    input  game_frame_clk_rising_edge, keycode, Attack1_On, Attack2_On, Game_Level,
    output Fire1, Fire2, Grant, Ready, Ammo
  );

endinterface

// File: rtl/attack_frame_timer.sv
// Loadable down-counter that decrements once per game frame tick and
// flags when it has reached zero.
module attack_frame_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= value;
    else if (tick && cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/attack_arbiter.sv
// Arbitrates Z/X key requests onto a single projectile launch slot with
// round-robin tie break, handshake timeout and per-attack cooldown.
// Optional attack2 ammo with frame-based refill: define ATTACK_AMMO_EN.
module attack_arbiter
  import attack_pkg::*;
#(
  parameter int unsigned COOLDOWN1     = 4,
  parameter int unsigned COOLDOWN2     = 8,
  parameter int unsigned TIMEOUT       = 31,
  parameter int unsigned AMMO_MAX      = 9,
  parameter int unsigned REFILL_FRAMES = 60
) (
  input logic              Clk,
  input logic              Reset,
  attack_arbiter_if.slave  bus
);

  state_e             state, state_next;
  grant_e             grant, grant_next, last_grant;
  logic               armed;
  logic [TO_W-1:0]    to_cnt;
  logic [AMMO_W-1:0]  ammo;
  logic               fire1, fire2, ready;
  logic               tick, req1, req2, ammo_ok, on_g, to_hit;
  logic               cd_load_en, cd_zero;
  logic [CD_W-1:0]    cd_value;
  logic               unused_lvl;

  assign tick = bus.game_frame_clk_rising_edge;
  assign req1 = (bus.keycode.lo == KEY_Z) || (bus.keycode.hi == KEY_Z);
  assign req2 = ((bus.keycode.lo == KEY_X) || (bus.keycode.hi == KEY_X)) && ammo_ok;
  assign on_g = (grant == GRANT_A1) ? bus.Attack1_On :
                (grant == GRANT_A2) ? bus.Attack2_On : 1'b0;
  // Fires on the frame tick that completes TIMEOUT ticks in the current state
  assign to_hit     = tick && (to_cnt >= TO_W'(TIMEOUT - 1));
  assign cd_value   = cooldown_load((grant == GRANT_A2) ? COOLDOWN2 : COOLDOWN1,
                                    bus.Game_Level[3:2]);
  assign cd_load_en = (state != ST_COOLDOWN) && (state_next == ST_COOLDOWN);
  assign unused_lvl = ^bus.Game_Level[1:0];

  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      ST_IDLE: begin
        if (armed && (req1 || req2)) begin
          state_next = ST_FIRE;
          if (req1 && req2) grant_next = (last_grant == GRANT_A1) ? GRANT_A2 : GRANT_A1;
          else              grant_next = req1 ? GRANT_A1 : GRANT_A2;
        end
      end
      ST_FIRE:   state_next = ST_LAUNCH;
      ST_LAUNCH: begin
        if (on_g)        state_next = ST_ACTIVE;
        else if (to_hit) state_next = ST_COOLDOWN;
      end
      ST_ACTIVE: begin
        if (!on_g || to_hit) state_next = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cd_zero) begin
          state_next = ST_IDLE;
          grant_next = GRANT_NONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = GRANT_NONE;
      end
    endcase
  end

  // armed holds off granting for the first cycle out of reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      grant      <= GRANT_NONE;
      last_grant <= GRANT_A2;
      armed      <= 1'b0;
      to_cnt     <= '0;
      fire1      <= 1'b0;
      fire2      <= 1'b0;
      ready      <= 1'b1;
    end else begin
      state <= state_next;
      grant <= grant_next;
      armed <= 1'b1;
      if (state == ST_COOLDOWN && state_next == ST_IDLE) last_grant <= grant;
      if (state_next != state)           to_cnt <= '0;
      else if (tick && to_cnt != '1)     to_cnt <= to_cnt + TO_W'(1);
      fire1 <= (state_next == ST_FIRE) && (grant_next == GRANT_A1);
      fire2 <= (state_next == ST_FIRE) && (grant_next == GRANT_A2);
      ready <= (state_next == ST_IDLE);
    end
  end

  attack_frame_timer #(.W(CD_W)) u_cooldown (
    .clk    (Clk),
    .rst    (Reset),
    .load   (cd_load_en),
    .value  (cd_value),
    .tick   (tick),
    .zero_c (cd_zero)
  );

`ifdef ATTACK_AMMO_EN
  localparam int unsigned RF_W = (REFILL_FRAMES > 1) ? $clog2(REFILL_FRAMES) : 1;
  logic [RF_W-1:0] refill_cnt;
  logic            spend, refill, full;

  assign full    = (ammo == AMMO_W'(AMMO_MAX));
  assign spend   = (state == ST_FIRE) && (grant == GRANT_A2);
  assign refill  = tick && !full && (refill_cnt == RF_W'(REFILL_FRAMES - 1));
  assign ammo_ok = (ammo != '0);

  // Refill period restarts whenever the magazine is full
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ammo       <= AMMO_W'(AMMO_MAX);
      refill_cnt <= '0;
    end else begin
      if (full)      refill_cnt <= '0;
      else if (tick) refill_cnt <= refill ? '0 : refill_cnt + RF_W'(1);
      if (spend && !refill)      ammo <= ammo - AMMO_W'(1);
      else if (refill && !spend) ammo <= ammo + AMMO_W'(1);
    end
  end
`else
  localparam int unsigned unused_refill_frames = REFILL_FRAMES;
  assign ammo    = AMMO_W'(AMMO_MAX);
  assign ammo_ok = 1'b1;
`endif

  assign bus.Fire1 = fire1;
  assign bus.Fire2 = fire2;
  assign bus.Grant = grant;
  assign bus.Ready = ready;
  assign bus.Ammo  = ammo;

endmodule
